// File: rtl/gcd_pkg.sv
// Shared types and default sizing for the GCD engine.
package gcd_pkg;

  localparam int WIDTH = 32;
  localparam int CNT_W = 32;

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    DONE
  } gcd_state_t;

endpackage

// File: rtl/sub.sv
// Existing 32-bit subtractor: Res = A - B (modulo 2^32).
module sub (
  input  logic [31:0] A,
  input  logic [31:0] B,
  output logic [31:0] Res
);

  assign Res = A - B;

endmodule

// File: rtl/gcd_engine.sv
// Iterative GCD by repeated subtraction. One operand pair is accepted on the
// input handshake, reduced one subtraction per cycle through the shared `sub`
// unit, and the GCD plus subtraction count is offered on the output handshake.
module gcd_engine #(
  parameter int WIDTH = gcd_pkg::WIDTH,
  parameter int CNT_W = gcd_pkg::CNT_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] gcd_out,
  output logic [CNT_W-1:0] iter_cnt,
  output logic             busy
);

  import gcd_pkg::*;

  gcd_state_t       state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] gcd_q, gcd_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] iter_q, iter_d;
  logic             out_valid_q, out_valid_d;

  logic             a_gt_b;
  logic [WIDTH-1:0] op_max, op_min, diff;
  logic [31:0]      sub_a, sub_b, sub_res;

  // Unsigned compare steers the larger operand to the minuend, so the
  // difference never underflows.
  always_comb begin
    a_gt_b = (a_q > b_q);
    op_max = a_gt_b ? a_q : b_q;
    op_min = a_gt_b ? b_q : a_q;
    sub_a  = 32'(op_max);
    sub_b  = 32'(op_min);
    diff   = WIDTH'(sub_res);
  end

  sub u_sub (
    .A   (sub_a),
    .B   (sub_b),
    .Res (sub_res)
  );

  // Next-state and next-datapath values; results are captured on entry to DONE.
  always_comb begin
    // NOTE: every output of this block gets a default first so no path leaves a latch.
    state_d     = state_q;
    a_d         = a_q;
    b_d         = b_q;
    cnt_d       = cnt_q;
    gcd_d       = gcd_q;
    iter_d      = iter_q;
    out_valid_d = out_valid_q;

    case (state_q)
      IDLE: begin
        if (in_valid) begin
          a_d     = a_in;
          b_d     = b_in;
          cnt_d   = '0;
          state_d = CALC;
        end
      end

      CALC: begin
        if (a_q == '0 || b_q == '0 || a_q == b_q) begin
          // A zero operand yields the other one; equal operands yield either.
          gcd_d       = (a_q == '0) ? b_q : a_q;
          iter_d      = cnt_q;
          out_valid_d = 1'b1;
          state_d     = DONE;
        end else begin
          if (a_gt_b) a_d = diff;
          else        b_d = diff;
          // Saturate rather than wrap so a huge job never reports a tiny count.
          if (cnt_q != '1) cnt_d = cnt_q + CNT_W'(1);
        end
      end

      DONE: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (rst) begin
      state_q     <= IDLE;
      a_q         <= '0;
      b_q         <= '0;
      cnt_q       <= '0;
      gcd_q       <= '0;
      iter_q      <= '0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      a_q         <= a_d;
      b_q         <= b_d;
      cnt_q       <= cnt_d;
      gcd_q       <= gcd_d;
      iter_q      <= iter_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign busy      = (state_q != IDLE);
  assign out_valid = out_valid_q;
  assign gcd_out   = gcd_q;
  assign iter_cnt  = iter_q;

endmodule

// File: tb/tb_gcd_engine.sv
// Self-checking bench for gcd_engine: directed plan vectors plus random
// operand pairs, compared against a division-based Euclid reference model.
module tb_gcd_engine;

  localparam int LIMIT = 4000;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] a_in;
  logic [31:0] b_in;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] gcd_out;
  logic [31:0] iter_cnt;
  logic        busy;

  int n_checks = 0;
  int n_fail   = 0;

  gcd_engine dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a_in      (a_in),
    .b_in      (b_in),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .gcd_out   (gcd_out),
    .iter_cnt  (iter_cnt),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Euclid by division: each quotient q counts q subtractions, except the
  // final exact division, whose last subtraction is replaced by the A==B stop.
  function automatic void ref_gcd(input logic [31:0] a, input logic [31:0] b,
                                  output logic [31:0] g, output longint unsigned n);
    longint unsigned x, y, q, r;
    n = 0;
    if (a == 0 || b == 0) begin
      g = a | b;
      return;
    end
    x = (a > b) ? a : b;
    y = (a > b) ? b : a;
    while (y != 0) begin
      q = x / y;
      r = x % y;
      n += (r == 0) ? q - 1 : q;
      x = y;
      y = r;
    end
    g = x[31:0];
  endfunction

  // Runs one job with out_ready high. Entered and left at a falling edge in IDLE.
  task automatic do_job(input logic [31:0] a, input logic [31:0] b, input bit noisy,
                        output logic [31:0] obs_g, output logic [31:0] obs_n);
    logic [31:0]     g;
    longint unsigned n;
    int              k;
    ref_gcd(a, b, g, n);
    check("idle_in_ready", in_ready, 1);
    in_valid = 1'b1;
    a_in     = a;
    b_in     = b;
    @(negedge clk);
    check("calc_flags", {in_ready, busy, out_valid}, 3'b010);
    k = 0;
    while (!out_valid && k < LIMIT) begin
      if (noisy) begin
        a_in = $urandom;
        b_in = $urandom;
      end else begin
        in_valid = 1'b0;
      end
      @(negedge clk);
      k++;
    end
    in_valid = 1'b0;
    check("latency", k, n + 1);
    check("gcd", gcd_out, g);
    check("iter", iter_cnt, n);
    check("done_flags", {in_ready, busy}, 2'b01);
    obs_g = gcd_out;
    obs_n = iter_cnt;
    @(negedge clk);
    check("retire_flags", {out_valid, in_ready, busy}, 3'b010);
    check("gcd_retained", gcd_out, g);
  endtask

  initial begin
    logic [31:0] og, on, ra, rb, f;
    int          k;

    rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    a_in      = '0;
    b_in      = '0;
    repeat (3) @(negedge clk);
    check("reset_flags", {out_valid, in_ready, busy}, 3'b010);
    check("reset_gcd", gcd_out, 0);
    check("reset_iter", iter_cnt, 0);
    rst = 1'b0;

    // Directed plan vectors
    do_job(48, 18, 1'b0, og, on);
    check("plan_48_18_gcd", og, 6);
    check("plan_48_18_iter", on, 4);
    do_job(17, 5, 1'b0, og, on);
    check("plan_17_5_iter", on, 6);
    do_job(5, 5, 1'b0, og, on);
    check("plan_5_5_gcd", og, 5);
    do_job(0, 7, 1'b0, og, on);
    do_job(9, 0, 1'b0, og, on);
    do_job(0, 0, 1'b0, og, on);

    // Backpressure: result must hold for 20 cycles with out_ready low
    out_ready = 1'b0;
    in_valid  = 1'b1;
    a_in      = 100;
    b_in      = 75;
    @(negedge clk);
    in_valid = 1'b0;
    k = 0;
    while (!out_valid && k < LIMIT) begin
      @(negedge clk);
      k++;
    end
    check("bp_latency", k, 4);
    for (int i = 0; i < 20; i++) begin
      check("bp_hold", {out_valid, in_ready, busy, gcd_out, iter_cnt}, {3'b101, 32'd25, 32'd3});
      @(negedge clk);
    end
    out_ready = 1'b1;
    @(negedge clk);
    check("bp_release", {out_valid, in_ready, busy}, 3'b010);
    check("bp_retained", {gcd_out, iter_cnt}, {32'd25, 32'd3});

    // Reset in the middle of a very long job
    in_valid = 1'b1;
    a_in     = 32'hFFFF_FFFF;
    b_in     = 32'd1;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (10) @(negedge clk);
    check("mid_busy", {in_ready, busy, out_valid}, 3'b010);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("midrst_flags", {out_valid, in_ready, busy}, 3'b010);
    check("midrst_gcd", gcd_out, 0);
    check("midrst_iter", iter_cnt, 0);
    do_job(12, 8, 1'b0, og, on);
    check("post_rst_gcd", og, 4);
    check("post_rst_iter", on, 2);

    // Inputs toggling during CALC must be ignored
    do_job(91, 35, 1'b1, og, on);

    // Random jobs; a shared factor keeps non-trivial GCDs common
    for (int i = 0; i < 24; i++) begin
      f  = $urandom_range(1, 12);
      ra = f * $urandom_range(0, 40);
      rb = f * $urandom_range(0, 40);
      if (i % 5 == 4) ra = $urandom_range(0, 400);
      do_job(ra, rb, (i % 3 == 0), og, on);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
